// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one multiplexed 8-bit memory port between the CPU (port 0) and the debug loader (port 1)
// Ports: reqN_* request handshakes (reqN_ready combinational), rspN_valid + rsp_rdata read responses,
// req1_lock lets port 1 hold the bus, mem_bus/mem_read/mem_write/mem_rdata drive the pins, busy/grant_id status.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LOCK_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  input  logic              req1_lock,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [DATA_W-1:0] mem_bus,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic              busy,
  output logic              grant_id
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;
  state_e state_q;
  logic rr_q, lock_q, wr_q, grant_q, busy_q, rd_q, wt_q, rsp0_q, rsp1_q;
  logic [DATA_W-1:0] bus_q, wdata_q, rdata_q;
  logic lock_eff, gnt_v, gnt_d, lock_d, w_sel;
  logic [ADDR_W-1:0] a_sel;
  logic [DATA_W-1:0] wd_sel;
  // a held lock only blocks port 0 while port 1 keeps req1_lock high; dropping it frees the bus this same cycle
  assign lock_eff = (LOCK_EN != 0) && lock_q && req1_lock;
  assign gnt_v = lock_eff ? req1_valid : (req0_valid || req1_valid);
  assign gnt_d = lock_eff ? 1'b1 : (req0_valid && req1_valid) ? rr_q : req1_valid;
  assign lock_d = (LOCK_EN != 0) && ((gnt_v && gnt_d) ? req1_lock : lock_eff);
  assign w_sel = gnt_d ? req1_write : req0_write;
  assign a_sel = gnt_d ? req1_addr : req0_addr;
  assign wd_sel = gnt_d ? req1_wdata : req0_wdata;
  assign req0_ready = (state_q == IDLE) && gnt_v && !gnt_d;
  assign req1_ready = (state_q == IDLE) && gnt_v && gnt_d;
  assign rsp0_valid = rsp0_q;
  assign rsp1_valid = rsp1_q;
  assign rsp_rdata = rdata_q;
  assign mem_bus = bus_q;
  assign mem_read = rd_q;
  assign mem_write = wt_q;
  assign busy = busy_q;
  assign grant_id = grant_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q <= 1'b0;
      lock_q <= 1'b0;
      wr_q <= 1'b0;
      grant_q <= 1'b0;
      busy_q <= 1'b0;
      rd_q <= 1'b0;
      wt_q <= 1'b0;
      rsp0_q <= 1'b0;
      rsp1_q <= 1'b0;
      bus_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          lock_q <= lock_d;
          if (gnt_v) begin
            state_q <= ADDR;
            grant_q <= gnt_d;
            rr_q <= !gnt_d;
            wr_q <= w_sel;
            wdata_q <= wd_sel;
            bus_q <= DATA_W'(a_sel);
            rd_q <= !w_sel;
            wt_q <= w_sel;
            busy_q <= 1'b1;
          end
        end
        ADDR: begin
          state_q <= DATA;
          rd_q <= 1'b0;
          wt_q <= 1'b0;
          bus_q <= wr_q ? wdata_q : '0;
          if (!wr_q) begin
            rdata_q <= mem_rdata;
            rsp0_q <= !grant_q;
            rsp1_q <= grant_q;
          end
        end
        DATA: begin
          state_q <= IDLE;
          bus_q <= '0;
          rsp0_q <= 1'b0;
          rsp1_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
